// File: rtl/mix_columns_seq.sv
// Iterative AES MixColumns: one 32-bit column per clock over four BUSY cycles,
// with a per-block bypass for the final round that keeps the same latency.
module mix_columns_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    input  logic         in_bypass,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t       state_q;
    logic [1:0]   col_q;
    logic [127:0] st_q;
    logic [127:0] st_d;
    logic         byp_q;
    logic [31:0]  cur_col;
    logic [31:0]  new_col;
    logic         accept;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
    endfunction

    // Column is {row0, row1, row2, row3} from MSB to LSB.
    function automatic logic [31:0] mix_col(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] b0, b1, b2, b3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        b0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        b3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

    assign in_ready  = (state_q == IDLE) | ((state_q == DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == DONE);
    assign out_state = st_q;

    always_comb begin
        cur_col = 32'h0;
        for (int c = 0; c < 4; c++) begin
            if (col_q == 2'(c)) begin
                cur_col = st_q[127 - 32*c -: 32];
            end
        end
        new_col = byp_q ? cur_col : mix_col(cur_col);
        st_d = st_q;
        for (int c = 0; c < 4; c++) begin
            if (col_q == 2'(c)) begin
                st_d[127 - 32*c -: 32] = new_col;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            col_q   <= 2'd0;
            st_q    <= 128'h0;
            byp_q   <= 1'b0;
        end else if (accept) begin
            state_q <= BUSY;
            col_q   <= 2'd0;
            st_q    <= in_state;
            byp_q   <= in_bypass;
        end else begin
            case (state_q)
                IDLE: begin
                end
                BUSY: begin
                    st_q  <= st_d;
                    col_q <= col_q + 2'd1;
                    if (col_q == 2'd3) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
